// File: rtl/exception_ctrl_pkg.sv
// Shared opcodes, state and cause encodings for the decode-stage exception controller.
package exception_ctrl_pkg;

    localparam logic [4:0] OP_SIIC = 5'b00010;
    localparam logic [4:0] OP_RTI  = 5'b00011;

    localparam logic [15:0] HANDLER_ADDR_DEF = 16'h0002;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        HANDLER = 2'd1,
        FAULT   = 2'd2
    } excState_t;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_SIIC    = 2'd1,
        CAUSE_ILLEGAL = 2'd2,
        CAUSE_FAULT   = 2'd3
    } excCause_t;

endpackage

// File: rtl/exception_ctrl_epc_reg.sv
// WIDTH-bit register with synchronous reset and load enable.
module exception_ctrl_epc_reg #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/exception_ctrl.sv
// Decode-stage exception controller: SIIC/illegal traps, RTI, double-fault detection.
// Optional macro EXC_CAUSE_EN adds the registered exc_cause output.
module exception_ctrl
    import exception_ctrl_pkg::*;
#(
    parameter int                 OP_SIZE      = 5,
    parameter int                 WIDTH        = 16,
    parameter logic [WIDTH-1:0]   HANDLER_ADDR = WIDTH'(HANDLER_ADDR_DEF)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic               id_stall,
    input  logic [OP_SIZE-1:0] id_opcode,
    input  logic               id_invalid_op,
    input  logic [WIDTH-1:0]   id_pc_plus2,
    output logic               exc_redirect,
    output logic [WIDTH-1:0]   exc_target,
    output logic               flush_if_id,
    output logic [WIDTH-1:0]   epc,
    output logic               in_handler,
    output logic               err
`ifdef EXC_CAUSE_EN
    ,
    output logic [1:0]         exc_cause
`endif
);

    excState_t        state;
    excState_t        stateNext;
    logic             accept;
    logic             isTrap;
    logic             isRet;
    logic             epcLoad;
    logic             tgtLoad;
    logic [WIDTH-1:0] tgtVal;
    logic             redirNext;
    logic             errNext;

    // The ID instruction seen during a redirect cycle is wrong-path.
    assign accept = id_valid & ~id_stall & ~exc_redirect;
    assign isTrap = accept
                  & (id_invalid_op | (id_opcode == OP_SIZE'(OP_SIIC)));
    assign isRet  = accept
                  & ~id_invalid_op & (id_opcode == OP_SIZE'(OP_RTI));

    always_comb begin
        stateNext = state;
        epcLoad   = 1'b0;
        tgtLoad   = 1'b0;
        tgtVal    = HANDLER_ADDR;
        redirNext = 1'b0;
        errNext   = err;
        unique case (state)
            RUN: begin
                if (isTrap) begin
                    epcLoad   = 1'b1;
                    tgtLoad   = 1'b1;
                    redirNext = 1'b1;
                    stateNext = HANDLER;
                end else if (isRet) begin
                    errNext   = 1'b1;
                    stateNext = FAULT;
                end
            end
            HANDLER: begin
                if (isRet) begin
                    tgtLoad   = 1'b1;
                    tgtVal    = epc;
                    redirNext = 1'b1;
                    stateNext = RUN;
                end else if (isTrap) begin
                    errNext   = 1'b1;
                    stateNext = FAULT;
                end
            end
            FAULT: begin
                errNext = 1'b1;
            end
            default: begin
                errNext   = 1'b1;
                stateNext = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            exc_redirect <= 1'b0;
            flush_if_id  <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= stateNext;
            exc_redirect <= redirNext;
            flush_if_id  <= redirNext;
            err          <= errNext;
        end
    end

    exception_ctrl_epc_reg #(.WIDTH(WIDTH)) uEpc (
        .clk  (clk),
        .rst  (rst),
        .load (epcLoad),
        .d    (id_pc_plus2),
        .q    (epc)
    );

    exception_ctrl_epc_reg #(.WIDTH(WIDTH)) uTarget (
        .clk  (clk),
        .rst  (rst),
        .load (tgtLoad),
        .d    (tgtVal),
        .q    (exc_target)
    );

    assign in_handler = (state == HANDLER);

`ifdef EXC_CAUSE_EN
    logic [1:0] causeNext;

    always_comb begin
        causeNext = exc_cause;
        if (state == RUN && isTrap) begin
            causeNext = id_invalid_op ? CAUSE_ILLEGAL : CAUSE_SIIC;
        end else if (state == RUN && isRet) begin
            causeNext = CAUSE_FAULT;
        end else if (state == HANDLER && isRet) begin
            causeNext = CAUSE_NONE;
        end else if (state == HANDLER && isTrap) begin
            causeNext = CAUSE_FAULT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exc_cause <= CAUSE_NONE;
        end else begin
            exc_cause <= causeNext;
        end
    end
`endif

endmodule

// File: tb/tb_exception_ctrl.sv
// Self-checking bench for exception_ctrl: directed plan plus randomized traffic vs. a rule model.
module tb_exception_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic        id_stall;
    logic [4:0]  id_opcode;
    logic        id_invalid_op;
    logic [15:0] id_pc_plus2;
    logic        exc_redirect;
    logic [15:0] exc_target;
    logic        flush_if_id;
    logic [15:0] epc;
    logic        in_handler;
    logic        err;
`ifdef EXC_CAUSE_EN
    logic [1:0]  exc_cause;
`endif

    exception_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_stall      (id_stall),
        .id_opcode     (id_opcode),
        .id_invalid_op (id_invalid_op),
        .id_pc_plus2   (id_pc_plus2),
        .exc_redirect  (exc_redirect),
        .exc_target    (exc_target),
        .flush_if_id   (flush_if_id),
        .epc           (epc),
        .in_handler    (in_handler),
        .err           (err)
`ifdef EXC_CAUSE_EN
        ,
        .exc_cause     (exc_cause)
`endif
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the controller is either running, inside the
    // handler, or dead; a redirect is a one-cycle pulse carrying a target.
    bit          mInH;
    bit          mDead;
    bit          mPulse;
    logic [15:0] mEpc;
    logic [15:0] mTgt;
    int          mCause;
    bit          started = 0;

    always @(posedge clk) begin
        bit take;
        bit trap;
        bit ret;
        started = 1;
        if (rst) begin
            mInH = 0; mDead = 0; mPulse = 0;
            mEpc = 0; mTgt = 0; mCause = 0;
        end else begin
            take   = id_valid && !id_stall && !mPulse && !mDead;
            trap   = id_invalid_op || (id_opcode == 5'd2);
            ret    = !id_invalid_op && (id_opcode == 5'd3);
            mPulse = 0;
            if (take) begin
                if ((trap && mInH) || (ret && !mInH)) begin
                    mDead = 1; mInH = 0; mCause = 3;
                end else if (trap) begin
                    mEpc = id_pc_plus2; mTgt = 16'h0002;
                    mPulse = 1; mInH = 1;
                    mCause = id_invalid_op ? 2 : 1;
                end else if (ret) begin
                    mTgt = mEpc; mPulse = 1; mInH = 0; mCause = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("redirect", 32'(exc_redirect), 32'(mPulse));
            check("flush", 32'(flush_if_id), 32'(mPulse));
            check("target", 32'(exc_target), 32'(mTgt));
            check("epc", 32'(epc), 32'(mEpc));
            check("in_handler", 32'(in_handler), 32'(mInH));
            check("err", 32'(err), 32'(mDead));
`ifdef EXC_CAUSE_EN
            check("cause", 32'(exc_cause), 32'(mCause));
`endif
        end
    end

    task automatic cyc(bit r, bit v, bit s, logic [4:0] op, bit inv,
                       logic [15:0] pc);
        rst = r; id_valid = v; id_stall = s;
        id_opcode = op; id_invalid_op = inv; id_pc_plus2 = pc;
        @(posedge clk);
        #1;
    endtask

    localparam logic [4:0] ADD  = 5'b11011;
    localparam logic [4:0] SIIC = 5'b00010;
    localparam logic [4:0] RTI  = 5'b00011;

    initial begin
        cyc(1, 0, 0, ADD, 0, 16'h0);
        cyc(1, 0, 0, ADD, 0, 16'h0);
        check("rst_redirect", 32'(exc_redirect), 0);
        check("rst_flush", 32'(flush_if_id), 0);
        check("rst_target", 32'(exc_target), 0);
        check("rst_epc", 32'(epc), 0);
        check("rst_inh", 32'(in_handler), 0);
        check("rst_err", 32'(err), 0);

        for (int i = 0; i < 10; i++) cyc(0, 1, 0, ADD, 0, 16'(i * 2));
        check("idle_redirect", 32'(exc_redirect), 0);
        check("idle_err", 32'(err), 0);

        cyc(0, 1, 0, SIIC, 0, 16'h0040);
        check("siic_redirect", 32'(exc_redirect), 1);
        check("siic_flush", 32'(flush_if_id), 1);
        check("siic_target", 32'(exc_target), 32'h0002);
        check("siic_epc", 32'(epc), 32'h0040);
        check("siic_inh", 32'(in_handler), 1);
        cyc(0, 1, 0, ADD, 0, 16'h0044);
        check("siic_pulse_end", 32'(exc_redirect), 0);
        check("siic_flush_end", 32'(flush_if_id), 0);

        cyc(0, 1, 0, RTI, 0, 16'h0099);
        check("rti_redirect", 32'(exc_redirect), 1);
        check("rti_target", 32'(exc_target), 32'h0040);
        check("rti_inh", 32'(in_handler), 0);
        check("rti_epc", 32'(epc), 32'h0040);
        cyc(0, 0, 0, ADD, 0, 16'h0);

        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 5'b01011, 1, 16'h0123);
            check("stall_no_redirect", 32'(exc_redirect), 0);
        end
        cyc(0, 1, 0, 5'b01011, 1, 16'h0123);
        check("ill_redirect", 32'(exc_redirect), 1);
        check("ill_epc", 32'(epc), 32'h0123);
`ifdef EXC_CAUSE_EN
        check("ill_cause", 32'(exc_cause), 2);
`endif
        cyc(0, 1, 0, 5'b01011, 1, 16'h0123);
        check("ill_once", 32'(exc_redirect), 0);

        cyc(0, 1, 0, SIIC, 0, 16'h0500);
        check("dbl_err", 32'(err), 1);
        check("dbl_redirect", 32'(exc_redirect), 0);
        check("dbl_epc", 32'(epc), 32'h0123);
        cyc(0, 1, 0, RTI, 0, 16'h0502);
        check("fault_rti_redirect", 32'(exc_redirect), 0);
        check("fault_err", 32'(err), 1);
        cyc(1, 0, 0, ADD, 0, 16'h0);
        check("rst_clears_err", 32'(err), 0);

        cyc(0, 1, 0, RTI, 0, 16'h0010);
        check("stray_err", 32'(err), 1);
`ifdef EXC_CAUSE_EN
        check("stray_cause", 32'(exc_cause), 3);
        cyc(1, 0, 0, ADD, 0, 16'h0);
        cyc(0, 1, 0, SIIC, 0, 16'h0020);
        check("siic_cause", 32'(exc_cause), 1);
`endif

        cyc(1, 0, 0, ADD, 0, 16'h0);
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] op;
            int sel = int'($urandom_range(0, 3));
            op = (sel == 0) ? ADD : (sel == 1) ? SIIC :
                 (sel == 2) ? RTI : 5'($urandom);
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 5) != 0),
                ($urandom_range(0, 3) == 0), op,
                ($urandom_range(0, 7) == 0), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
- Decode-stage exception controller for the 16-bit 5-stage pipeline.
- Consumes the invalid-opcode flag and the raw 5-bit opcode of the instruction in ID.
- Handles SIIC and illegal instructions: saves EPC, redirects fetch to the handler, and flushes IF/ID.
- Handles RTI: returns to EPC. Detects double faults and stray RTIs, and reports them on err.

Parameters:
- OP_SIZE, 5, opcode width.
- WIDTH, 16, PC/EPC width.
- HANDLER_ADDR, 16'h0002, exception handler entry PC.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real (non-bubble) instruction.
- id_stall  in  1  ID is stalled this cycle; instruction not committed to decode.
- id_opcode  in  OP_SIZE  opcode of the ID instruction.
- id_invalid_op  in  1  from the invalid-opcode checker; 1 = opcode not in the ISA.
- id_pc_plus2  in  WIDTH  PC+2 of the ID instruction.
- exc_redirect  out  1  registered; fetch must load exc_target next cycle.
- exc_target  out  WIDTH  registered redirect PC.
- flush_if_id  out  1  registered; squash the IF/ID register contents.
- epc  out  WIDTH  saved return PC.
- in_handler  out  1  state == HANDLER.
- err  out  1  sticky fault indicator.

Behaviour:
- Reset (rst=1 at a clk edge) gives:
  - state=RUN, epc=0, exc_redirect=0, exc_target=0, flush_if_id=0, err=0.
  - rst overrides every other input, including a mid-redirect or HANDLER state.
- Accept: accept = id_valid & ~id_stall & ~exc_redirect.
  - The instruction in ID during a redirect cycle is wrong-path and is ignored.
- Events, evaluated only when accept=1:
  - TRAP = id_invalid_op | (id_opcode==OP_SIIC).
  - RET = ~id_invalid_op & (id_opcode==OP_RTI).
- State RUN:
  - TRAP: epc<=id_pc_plus2, exc_target<=HANDLER_ADDR, exc_redirect<=1, flush_if_id<=1, go HANDLER.
  - RET: stray RTI. err<=1, go FAULT, no redirect.
- State HANDLER:
  - RET: exc_target<=epc, exc_redirect<=1, flush_if_id<=1, go RUN.
  - TRAP (double fault): err<=1, go FAULT. epc is not overwritten. No redirect.
- State FAULT:
  - Terminal until rst. Ignores all events. err held at 1. exc_redirect held at 0.
- Pulse and latency rules:
  - exc_redirect and flush_if_id are single-cycle pulses, asserted exactly 1 cycle after the accepting edge.
  - Deasserted in the following cycle regardless of inputs.
- Stall/valid:
  - id_stall=1 or id_valid=0 leaves state and epc unchanged.
  - An event held across a stall is taken once, on the first unstalled cycle.
- epc:
  - Changes only on an accepted TRAP in RUN.
  - Width-exact copy; no arithmetic is performed in this block.
- id_invalid_op=1 always classifies as TRAP, even if id_opcode bits coincide with RTI.

Optional Feature:
- Macro: EXC_CAUSE_EN.
- When defined, adds output exc_cause[1:0], registered, reset 0. Encoding:
  - 0 = none.
  - 1 = SIIC.
  - 2 = illegal opcode.
  - 3 = double fault / stray RTI.
- exc_cause updates on the same edge as the state change. A RET back to RUN clears it to 0.
- When undefined, the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - OP_SIIC=5'b00010, OP_RTI=5'b00011.
  - State encoding RUN=2'd0, HANDLER=2'd1, FAULT=2'd2.
  - Cause codes.
  - HANDLER_ADDR default.
- One natural sub-module: epc_reg, a WIDTH-bit register with sync reset and load enable.
  - Reused for the exc_target register.

Test Plan:
1. rst for 2 cycles -> all outputs 0, in_handler=0. Then idle valid ADD (5'b11011) for 10 cycles -> no redirect, err=0.
2. SIIC accepted with id_pc_plus2=16'h0040 -> next cycle exc_redirect=1, flush_if_id=1, exc_target=16'h0002, epc=16'h0040, in_handler=1; following cycle both pulses 0.
3. From test 2, RTI accepted -> next cycle exc_redirect=1, exc_target=16'h0040, in_handler=0; epc remains 16'h0040.
4. Opcode 5'b01011 with id_invalid_op=1 and id_stall=1 for 3 cycles, then stall released -> exactly one redirect pulse, 1 cycle after release; epc=id_pc_plus2 at release.
5. In HANDLER, a second SIIC accepted -> err=1, state FAULT, no redirect, epc unchanged; subsequent RTI ignored; rst clears err.
6. RTI in RUN -> err=1. With EXC_CAUSE_EN defined: exc_cause=3; a prior illegal-opcode trap gives exc_cause=2, SIIC gives 1.
